// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: RUN / MEM_WAIT / RESUME FSM plus fixed-priority hazard strobes.
// Optional perf counters are built when PIPE_PERF_CNT_EN is defined; otherwise their ports read 0.
module pipe_hazard_ctrl #(
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             mem_stall_i,
    input  logic             idex_memread_i,
    input  logic [4:0]       idex_rt_i,
    input  logic [5:0]       ifid_op_i,
    input  logic [4:0]       ifid_rs_i,
    input  logic [4:0]       ifid_rt_i,
    input  logic             branch_taken_i,
    input  logic             jump_i,
    output logic             pc_hold_o,
    output logic             ifid_hold_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             pipe_stall_o,
    output logic [1:0]       state_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] stall_cyc_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        RESUME   = 2'd2
    } state_t;

    typedef struct packed {
        logic pc_hold;
        logic ifid_hold;
        logic ifid_flush;
        logic idex_bubble;
        logic pipe_stall;
    } ctl_t;

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    state_t         state, state_nx;
    ctl_t           ctl, ctl_g;
    logic           lu;
    logic [TW-1:0]  to_cnt, to_cnt_nx;
    logic           timeout;

    assign lu = idex_memread_i && (idex_rt_i != 5'd0) &&
                ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i)) &&
                (ifid_op_i != 6'b111111);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= RUN;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ctl      = '0;
        case (state)
            RUN: begin
                if (mem_stall_i) begin
                    state_nx       = MEM_WAIT;
                    ctl.pc_hold    = 1'b1;
                    ctl.ifid_hold  = 1'b1;
                    ctl.pipe_stall = 1'b1;
                end else if (lu) begin
                    // Branch in ID is dropped here; it re-evaluates once the bubble passes.
                    ctl.pc_hold     = 1'b1;
                    ctl.ifid_hold   = 1'b1;
                    ctl.idex_bubble = 1'b1;
                end else if (branch_taken_i || jump_i) begin
                    ctl.ifid_flush = 1'b1;
                end
            end
            MEM_WAIT: begin
                ctl.pc_hold    = 1'b1;
                ctl.ifid_hold  = 1'b1;
                ctl.pipe_stall = 1'b1;
                if (!mem_stall_i) state_nx = RESUME;
            end
            RESUME: begin
                // Back end runs one cycle so the stalled load can retire; front end stays held.
                ctl.pc_hold   = 1'b1;
                ctl.ifid_hold = 1'b1;
                state_nx      = RUN;
            end
            default: state_nx = RUN;
        endcase
    end

    // Strobes are forced low while reset is asserted regardless of inputs.
    assign ctl_g = rst_i ? ctl : '0;

    assign pc_hold_o     = ctl_g.pc_hold;
    assign ifid_hold_o   = ctl_g.ifid_hold;
    assign ifid_flush_o  = ctl_g.ifid_flush;
    assign idex_bubble_o = ctl_g.idex_bubble;
    assign pipe_stall_o  = ctl_g.pipe_stall;
    assign state_o       = state;
    assign timeout_o     = timeout;

    assign to_cnt_nx = (to_cnt == TW'(TIMEOUT_CYC)) ? to_cnt : to_cnt + 1'b1;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            to_cnt  <= '0;
            timeout <= 1'b0;
        end else if (state == RUN && mem_stall_i) begin
            to_cnt <= '0;
        end else if (state == MEM_WAIT) begin
            to_cnt <= to_cnt_nx;
            if (to_cnt_nx == TW'(TIMEOUT_CYC)) timeout <= 1'b1;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cyc, flush_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cyc <= '0;
            flush_cnt <= '0;
        end else begin
            if (ctl_g.pc_hold && stall_cyc != '1)    stall_cyc <= stall_cyc + 1'b1;
            if (ctl_g.ifid_flush && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign stall_cyc_o = stall_cyc;
    assign flush_cnt_o = flush_cnt;
`else
    assign stall_cyc_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule
